q3fsm_stream_gen: RTL and testbench

Transmit side of the 3-cycle w-window protocol used by our `q3fsm` detectors. Accepts 3-bit window words over a valid/ready handshake and issues a single `s` start pulse. It then serializes the words onto `w` back-to-back, one bit per cycle, MSB first, forever until reset. Alongside the stream it drives `z_expect`, the cycle-exact `z` a conforming detector must produce, for use as a scoreboard reference in the detector verification bench.

---
 rtl/q3fsm_stream_gen.sv | 105 ++++++++++
 tb/tb_q3fsm_stream_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q3fsm_stream_gen.sv
// Transmit side of the q3fsm window protocol: one start pulse, then 3-bit
// words serialized MSB first forever, with the detector's expected z alongside.
module q3fsm_stream_gen #(
    parameter logic [2:0] FILL  = 3'b000,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_data,
    output logic             s,
    output logic             w,
    output logic             z_expect,
    output logic             started,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] cur;
    logic [1:0] idx;
    logic [2:0] nxt;
    logic       nxt_valid;
    logic       take;
    logic       load;
    logic       fill;
    logic [2:0] load_word;
    logic       two_ones;

    assign in_ready = !nxt_valid;
    assign take     = in_valid && !nxt_valid;
    assign load     = (state == START) || (state == STREAM && idx == 2'd2);
    assign fill     = !nxt_valid && !take;
    assign two_ones = (cur == 3'b011) || (cur == 3'b101) || (cur == 3'b110);

    // Holding register wins, then a same-cycle transfer bypasses, else FILL.
    always_comb begin
        load_word = FILL;
        if (nxt_valid)
            load_word = nxt;
        else if (take)
            load_word = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cur          <= 3'b000;
            idx          <= 2'd0;
            nxt          <= 3'b000;
            nxt_valid    <= 1'b0;
            s            <= 1'b0;
            w            <= 1'b0;
            z_expect     <= 1'b0;
            started      <= 1'b0;
            win_cnt      <= '0;
            underrun_cnt <= '0;
        end else begin
            s        <= 1'b0;
            z_expect <= 1'b0;
            if (load) begin
                cur       <= load_word;
                w         <= load_word[2];
                idx       <= 2'd0;
                nxt_valid <= 1'b0;
                if (fill && underrun_cnt != {CNT_W{1'b1}})
                    underrun_cnt <= underrun_cnt + CNT_W'(1);
            end else if (take) begin
                nxt       <= in_data;
                nxt_valid <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    w <= 1'b0;
                    if (take) begin
                        state <= START;
                        s     <= 1'b1;
                    end
                end
                START: begin
                    state   <= STREAM;
                    started <= 1'b1;
                end
                STREAM: begin
                    if (idx == 2'd2) begin
                        z_expect <= two_ones;
                        win_cnt  <= win_cnt + CNT_W'(1);
                    end else begin
                        idx <= idx + 2'd1;
                        w   <= (idx == 2'd0) ? cur[1] : cur[0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q3fsm_stream_gen.sv
// Directed and scoreboarded checks of q3fsm_stream_gen, including a
// behavioural window detector used as the z reference.
module tb_q3fsm_stream_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       s;
    logic       w;
    logic       z_expect;
    logic       started;
    logic [7:0] win_cnt;
    logic [7:0] underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    q3fsm_stream_gen dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .s            (s),
        .w            (w),
        .z_expect     (z_expect),
        .started      (started),
        .win_cnt      (win_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 3'b000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [2:0]  words [200];
    logic [2:0]  cwords [4];
    logic [2:0]  sb [$];
    logic [11:0] wvec;
    logic [13:0] zvec;
    logic [2:0]  win;
    logic [2:0]  expw;
    int          wi;
    int          cnt;
    int          ones;
    int          nwin;
    int          off;
    logic        det_on;
    logic        zq;
    logic        zn;
    logic        acc;

    initial begin
        // Reset state
        do_reset();
        chk("rst_s", s, 0);
        chk("rst_w", w, 0);
        chk("rst_z", z_expect, 0);
        chk("rst_started", started, 0);
        chk("rst_win", win_cnt, 0);
        chk("rst_urun", underrun_cnt, 0);
        chk("rst_rdy", in_ready, 1);

        // Single word 110 then underrun
        in_valid = 1'b1;
        in_data  = 3'b110;
        tick();
        in_valid = 1'b0;
        chk("t1_s", s, 1);
        chk("t1_w0", w, 0);
        chk("t1_rdy_start", in_ready, 0);
        tick();
        chk("t1_b2", w, 1);
        chk("t1_started", started, 1);
        chk("t1_s_low", s, 0);
        tick();
        chk("t1_b1", w, 1);
        tick();
        chk("t1_b0", w, 0);
        chk("t1_z_b0", z_expect, 0);
        tick();
        chk("t1_z", z_expect, 1);
        chk("t1_win", win_cnt, 1);
        chk("t1_urun1", underrun_cnt, 1);
        tick();
        chk("t1_z_off", z_expect, 0);
        chk("t1_urun1b", underrun_cnt, 1);
        tick();
        tick();
        chk("t1_urun2", underrun_cnt, 2);
        chk("t1_z_fill", z_expect, 0);
        tick();
        tick();
        tick();
        chk("t1_urun3", underrun_cnt, 3);

        // Continuous words, in_valid held while data remains
        do_reset();
        cwords[0] = 3'b011;
        cwords[1] = 3'b111;
        cwords[2] = 3'b101;
        cwords[3] = 3'b000;
        wi  = 0;
        off = -1;
        wvec = '0;
        zvec = '0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (wi < 4);
            in_data  = (wi < 4) ? cwords[wi] : 3'b000;
            if (s) off = 0;
            else if (off >= 0) off++;
            if (off >= 1 && off <= 12) wvec = {wvec[10:0], w};
            if (off >= 1 && off <= 13) zvec[off] = z_expect;
            if (off == 12) chk("t2_urun", underrun_cnt, 0);
            if (off == 13) chk("t2_win", win_cnt, 4);
            acc = in_valid && in_ready;
            tick();
            if (acc) wi++;
        end
        chk("t2_wseq", wvec, 12'b011111101000);
        chk("t2_zseq", zvec, 14'b00_0100_0001_0000);

        // Bypass on a load cycle with nxt empty
        do_reset();
        in_valid = 1'b1;
        in_data  = 3'b001;
        tick();
        in_valid = 1'b0;
        chk("t4_s", s, 1);
        tick();
        tick();
        tick();
        chk("t4_b0", w, 1);
        chk("t4_rdy", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 3'b100;
        tick();
        in_valid = 1'b0;
        chk("t4_byp2", w, 1);
        chk("t4_z", z_expect, 0);
        chk("t4_rdy_after", in_ready, 1);
        tick();
        chk("t4_byp1", w, 0);
        chk("t4_urun", underrun_cnt, 0);

        // Reset mid-window at bit index 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_w", w, 0);
        chk("t5_s", s, 0);
        chk("t5_started", started, 0);
        chk("t5_win", win_cnt, 0);
        chk("t5_urun", underrun_cnt, 0);
        chk("t5_rdy", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 3'b011;
        tick();
        in_valid = 1'b0;
        chk("t5_s_again", s, 1);
        chk("t5_started0", started, 0);
        tick();
        chk("t5_started1", started, 1);
        chk("t5_b2", w, 0);

        // 200 random words: scoreboard, handshake and detector reference
        do_reset();
        for (int i = 0; i < 200; i++) words[i] = 3'($urandom_range(0, 7));
        sb.delete();
        wi     = 0;
        cnt    = 0;
        ones   = 0;
        nwin   = 0;
        det_on = 1'b0;
        zq     = 1'b0;
        win    = '0;
        for (int c = 0; c < 1500 && nwin < 200; c++) begin
            in_valid = (wi < 200);
            in_data  = (wi < 200) ? words[wi] : 3'b000;
            chk("loop_z", z_expect, zq);
            if (det_on && !s && wi < 200)
                chk("loop_rdy", in_ready, (cnt == 0));
            zn = 1'b0;
            if (s) begin
                det_on = 1'b1;
                cnt    = 0;
                ones   = 0;
            end else if (det_on) begin
                win = {win[1:0], w};
                ones += int'(w);
                cnt++;
                if (cnt == 3) begin
                    zn = (ones == 2);
                    if (sb.size() == 0) begin
                        chk("loop_sb_empty", 0, 1);
                    end else begin
                        expw = sb.pop_front();
                        chk("loop_win", win, expw);
                    end
                    nwin++;
                    cnt  = 0;
                    ones = 0;
                    if (nwin == 200) chk("loop_urun", underrun_cnt, 0);
                end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                sb.push_back(words[wi]);
                wi++;
            end
            zq = zn;
        end
        chk("loop_nwin", nwin, 200);
        chk("loop_z_last", z_expect, zq);
        chk("loop_win_cnt", win_cnt, 200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
